// File: rtl/mips_cpu_bus_arbiter.sv
// Arbitrates one Avalon master port between the instruction-fetch and data ports.
// A stall counter raises a sticky timeout flag. Define MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mips_cpu_bus_arbiter #(
  parameter int STALL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        timeout,
  output logic [1:0]  debug_state
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] pick;
  logic       armed;
  logic       i_pend;
  logic       d_pend;
  logic       owner_strobe;
  logic       done;
  logic [7:0] stall_cnt;
  logic [7:0] stall_next;
  logic       timeout_next;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 when the data port received the most recent grant

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (state_next == GNT_I) begin
      last_d <= 1'b0;
    end else if (state_next == GNT_D) begin
      last_d <= 1'b1;
    end
  end

  always_comb begin
    pick = IDLE;
    if (i_pend && d_pend) pick = last_d ? GNT_I : GNT_D;
    else if (d_pend)      pick = GNT_D;
    else if (i_pend)      pick = GNT_I;
  end
`else
  always_comb begin
    pick = IDLE;
    if (d_pend)      pick = GNT_D;
    else if (i_pend) pick = GNT_I;
  end
`endif

  always_comb begin
    owner_strobe = 1'b0;
    case (state)
      GNT_I:   owner_strobe = i_pend;
      GNT_D:   owner_strobe = d_pend;
      default: owner_strobe = 1'b0;
    endcase
  end

  assign done = owner_strobe & ~waitrequest;

  // A dropped strobe abandons the grant; a completion re-arbitrates without an IDLE gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = armed ? pick : IDLE;
      GNT_I, GNT_D: begin
        if (!owner_strobe) state_next = IDLE;
        else if (done)     state_next = pick;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_next = stall_cnt;
    if ((state_next != state) || done) begin
      stall_next = 8'd0;
    end else if ((state != IDLE) && waitrequest && (stall_cnt != 8'hFF)) begin
      stall_next = stall_cnt + 8'd1;
    end
  end

  assign timeout_next = timeout |
                        ((stall_next != 8'd0) && (int'({24'd0, stall_next}) >= STALL_LIMIT));

  // armed delays the first arbitration to the second edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      stall_cnt <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      armed     <= 1'b1;
      stall_cnt <= stall_next;
      timeout   <= timeout_next;
    end
  end

  always_comb begin
    address    = 32'd0;
    writedata  = 32'd0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'd0;
    case (state)
      GNT_I: begin
        address    = i_address;
        read       = i_read;
        byteenable = 4'b1111;
      end
      GNT_D: begin
        address    = d_address;
        writedata  = d_writedata;
        read       = d_read & ~d_write;
        write      = d_write;
        byteenable = d_byteenable;
      end
      default: begin
        address    = 32'd0;
        writedata  = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'd0;
      end
    endcase
  end

  assign i_waitrequest = i_pend & ~((state == GNT_I) & ~waitrequest);
  assign d_waitrequest = d_pend & ~((state == GNT_D) & ~waitrequest);
  assign i_readdata    = readdata;
  assign d_readdata    = readdata;
  assign debug_state   = state;
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed scenarios plus random two-port traffic against a behavioural model.
// Follows MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mips_cpu_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = 32'd0;
  logic        i_read = 1'b0;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic [31:0] d_address = 32'd0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = 32'd0;
  logic [3:0]  d_byteenable = 4'd0;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'd0;
  logic        waitrequest = 1'b0;
  logic        timeout;
  logic [1:0]  debug_state;

  int errors = 0;
  int checks = 0;

  mips_cpu_bus_arbiter #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .address(address), .writedata(writedata), .read(read), .write(write), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest), .timeout(timeout), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus (0 nobody, 1 fetch, 2 data), stall length, sticky flag.
  int m_owner = 0;
  bit m_armed = 1'b0;
  int m_stall = 0;
  bit m_tmo = 1'b0;
  bit m_i_done = 1'b0;
  bit m_d_done = 1'b0;
`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
  int m_last = 1;
`endif
  bit m_ip, m_dp, m_strobe, m_done;
  int m_nxt;

  function automatic int arbitrate(input bit ip, input bit dp);
    if (ip && dp) begin
`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 2;
`endif
    end
    if (dp) return 2;
    if (ip) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    m_ip = i_read;
    m_dp = d_read | d_write;
    if (reset) begin
      m_owner = 0; m_armed = 1'b0; m_stall = 0; m_tmo = 1'b0;
      m_i_done = 1'b0; m_d_done = 1'b0;
`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
      m_last = 1;
`endif
    end else begin
      m_strobe = (m_owner == 1) ? m_ip : (m_owner == 2) ? m_dp : 1'b0;
      m_done   = m_strobe && !waitrequest;
      m_i_done = m_done && (m_owner == 1);
      m_d_done = m_done && (m_owner == 2);
      if (m_owner == 0)  m_nxt = m_armed ? arbitrate(m_ip, m_dp) : 0;
      else if (!m_strobe) m_nxt = 0;
      else if (m_done)   m_nxt = arbitrate(m_ip, m_dp);
      else               m_nxt = m_owner;
      if ((m_nxt != m_owner) || m_done) m_stall = 0;
      else if ((m_owner != 0) && waitrequest) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
      if (m_stall >= LIMIT) m_tmo = 1'b1;
`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
      if (m_nxt != 0) m_last = m_nxt;
`endif
      m_armed = 1'b1;
      m_owner = m_nxt;
    end
  end

  int          c_own;
  logic [31:0] e_addr, e_wd;
  logic        e_rd, e_wr;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    c_own  = reset ? 0 : m_owner;
    e_addr = 32'd0; e_wd = 32'd0; e_rd = 1'b0; e_wr = 1'b0; e_be = 4'd0;
    if (c_own == 1) begin
      e_addr = i_address; e_rd = i_read; e_be = 4'hF;
    end else if (c_own == 2) begin
      e_addr = d_address; e_wd = d_writedata; e_rd = d_read && !d_write;
      e_wr = d_write; e_be = d_byteenable;
    end
    check("address", address, e_addr);
    check("writedata", writedata, e_wd);
    check("read", {31'd0, read}, {31'd0, e_rd});
    check("write", {31'd0, write}, {31'd0, e_wr});
    check("byteenable", {28'd0, byteenable}, {28'd0, e_be});
    check("i_waitrequest", {31'd0, i_waitrequest},
          {31'd0, i_read && !(c_own == 1 && !waitrequest)});
    check("d_waitrequest", {31'd0, d_waitrequest},
          {31'd0, (d_read || d_write) && !(c_own == 2 && !waitrequest)});
    check("i_readdata", i_readdata, readdata);
    check("d_readdata", d_readdata, readdata);
    check("timeout", {31'd0, timeout}, {31'd0, !reset && m_tmo});
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic new_data_req();
    int op;
    op = $urandom_range(0, 4);
    d_read       = (op <= 1) || (op == 4);
    d_write      = (op >= 2);
    d_address    = $urandom() & 32'hFFFF_FFFC;
    d_writedata  = $urandom();
    d_byteenable = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_fetch();
    if (!i_read) begin
      if ($urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_address = $urandom() & 32'hFFFF_FFFC;
      end
    end else if (m_i_done) begin
      if ($urandom_range(0, 1) == 0) i_address = $urandom() & 32'hFFFF_FFFC;
      else i_read = 1'b0;
    end else if ($urandom_range(0, 39) == 0) begin
      i_read = 1'b0;
    end
  endtask

  task automatic drive_data();
    if (!(d_read || d_write)) begin
      if ($urandom_range(0, 2) == 0) new_data_req();
    end else if (m_d_done) begin
      if ($urandom_range(0, 1) == 0) new_data_req();
      else begin d_read = 1'b0; d_write = 1'b0; end
    end else if ($urandom_range(0, 39) == 0) begin
      d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  initial begin
    do_reset();
    neg();
    check("rst_address", address, 32'd0);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    next_cycle();

    // Simultaneous fetch and store right after reset.
    i_read = 1'b1; i_address = 32'h20;
    d_write = 1'b1; d_address = 32'h100; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    neg();
    check("arb_idle_write", {31'd0, write}, 32'd0);
    next_cycle(); neg();
    check("gnt_d_address", address, 32'h100);
    check("gnt_d_writedata", writedata, 32'hDEADBEEF);
    check("gnt_d_byteenable", {28'd0, byteenable}, 32'h3);
    check("gnt_d_write", {31'd0, write}, 32'd1);
    check("gnt_d_complete", {31'd0, d_waitrequest}, 32'd0);
`ifdef MIPS_CPU_BUS_ARB_ROUND_ROBIN_EN
    next_cycle(); d_write = 1'b0; neg();
    check("rr_fetch_read", {31'd0, read}, 32'd1);
    check("rr_fetch_address", address, 32'h20);
    check("rr_fetch_iwait", {31'd0, i_waitrequest}, 32'd0);
`else
    for (int k = 0; k < 10; k++) begin
      next_cycle(); neg();
      check("starve_write", {31'd0, write}, 32'd1);
      check("starve_read", {31'd0, read}, 32'd0);
      check("starve_iwait", {31'd0, i_waitrequest}, 32'd1);
    end
`endif
    next_cycle(); clear_inputs();
    next_cycle(); next_cycle();

    // Fetch with two memory wait cycles.
    i_read = 1'b1; i_address = 32'h10; waitrequest = 1'b1;
    neg();
    check("fetch_c0_read", {31'd0, read}, 32'd0);
    next_cycle(); neg();
    check("fetch_c1_read", {31'd0, read}, 32'd1);
    check("fetch_c1_address", address, 32'h10);
    check("fetch_c1_iwait", {31'd0, i_waitrequest}, 32'd1);
    next_cycle(); neg();
    check("fetch_c2_iwait", {31'd0, i_waitrequest}, 32'd1);
    next_cycle(); waitrequest = 1'b0; readdata = 32'hCAFE0010; neg();
    check("fetch_c3_iwait", {31'd0, i_waitrequest}, 32'd0);
    check("fetch_c3_data", i_readdata, 32'hCAFE0010);
    next_cycle(); clear_inputs();
    next_cycle(); next_cycle();

    // Load stalled for the full limit.
    d_read = 1'b1; d_address = 32'h44; waitrequest = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle(); neg();
      check("tmo_before_limit", {31'd0, timeout}, 32'd0);
    end
    next_cycle(); waitrequest = 1'b0; readdata = 32'h12345678; neg();
    check("tmo_raised", {31'd0, timeout}, 32'd1);
    check("load_data", d_readdata, 32'h12345678);
    check("load_dwait", {31'd0, d_waitrequest}, 32'd0);
    next_cycle(); clear_inputs();
    for (int k = 0; k < 3; k++) begin
      next_cycle(); neg();
      check("tmo_sticky", {31'd0, timeout}, 32'd1);
    end

    // Reset during a stalled store.
    next_cycle();
    d_write = 1'b1; d_address = 32'h80; d_writedata = 32'h5555AAAA; d_byteenable = 4'hF;
    waitrequest = 1'b1;
    next_cycle(); neg();
    check("pre_rst_write", {31'd0, write}, 32'd1);
    next_cycle(); #2; reset = 1'b1; #1;
    check("mid_rst_write", {31'd0, write}, 32'd0);
    check("mid_rst_address", address, 32'd0);
    check("mid_rst_byteenable", {28'd0, byteenable}, 32'd0);
    check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    check("mid_rst_dwait", {31'd0, d_waitrequest}, 32'd1);
    next_cycle(); reset = 1'b0; neg();
    check("release_c0_write", {31'd0, write}, 32'd0);
    next_cycle(); neg();
    check("release_c1_write", {31'd0, write}, 32'd0);
    next_cycle(); neg();
    check("release_c2_write", {31'd0, write}, 32'd1);
    next_cycle(); waitrequest = 1'b0; neg();
    check("release_complete", {31'd0, d_waitrequest}, 32'd0);
    next_cycle(); clear_inputs();
    next_cycle(); next_cycle();

    // Read and write together: the write wins the bus strobes.
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h40; d_writedata = 32'h0BADF00D;
    d_byteenable = 4'b0101;
    next_cycle(); neg();
    check("rw_write", {31'd0, write}, 32'd1);
    check("rw_read", {31'd0, read}, 32'd0);
    check("rw_byteenable", {28'd0, byteenable}, 32'h5);
    check("rw_address", address, 32'h40);
    next_cycle(); clear_inputs();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      reset = (cyc % 600 == 599);
      drive_fetch();
      drive_data();
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata = $urandom();
    end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
